// File: rtl/fde_pkg.sv
// ----------------------------------------------------------------------------
// fde_pkg
//   Shared definitions for the writeback stage: field positions inside the
//   71-bit EX_WB bundle and the writeback state encoding.
//   Bundle layout: [31:0] wdata, [63:32] pc, [68:64] dest, [69] branch,
//   [70] writeback enable.
// ----------------------------------------------------------------------------
package fde_pkg;

  localparam int EXWB_W    = 71;
  localparam int WDATA_LSB = 0;
  localparam int PC_LSB    = 32;
  localparam int DEST_LSB  = 64;
  localparam int BR_BIT    = 69;
  localparam int WE_BIT    = 70;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } wb_state_t;

endpackage

// File: rtl/wb_regfile.sv
// ----------------------------------------------------------------------------
// wb_regfile
//   32x32 general register file: one synchronous write port, two
//   combinational read ports. r0 is never written and always reads zero.
//   All registers clear on the asynchronous active-low reset.
//
//   Optional macro WB_BYPASS_EN: when defined, a read port whose address
//   matches the write committing this cycle returns the write data directly;
//   otherwise the port returns the stored (pre-write) value.
//
// Ports
//   clock, reset_n     : clock and asynchronous active-low reset
//   we, waddr, wdata   : write port (waddr = 0 is ignored)
//   rs_addr / rs_data  : read port A
//   rt_addr / rt_data  : read port B
// ----------------------------------------------------------------------------
module wb_regfile #(
  parameter int RF_DEPTH = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data
);

  // Flop-based storage: the whole file must clear on reset, so this cannot
  // be mapped to a block RAM.
  logic [31:0] rf_q [RF_DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        rf_q[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      rf_q[waddr] <= wdata;
    end
  end

  // Two identical read ports; port 0 is rs, port 1 is rt.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [4:0]  addr;
      logic [31:0] data;

      assign addr = (gi == 0) ? rs_addr : rt_addr;

      always_comb begin
        data = (addr == 5'd0) ? 32'd0 : rf_q[addr];
`ifdef WB_BYPASS_EN
        if (we && (waddr != 5'd0) && (addr == waddr)) begin
          data = wdata;
        end
`endif
      end
    end
  endgenerate

  assign rs_data = g_rd[0].data;
  assign rt_data = g_rd[1].data;

endmodule

// File: rtl/wb_stage.sv
// ----------------------------------------------------------------------------
// wb_stage
//   Writeback stage. Commits EX_WB entries into the register file, counts
//   retired entries, turns branch-flagged entries into a held redirect
//   request to fetch, and squashes FLUSH_DEPTH valid wrong-path entries once
//   the redirect has been acknowledged.
//
//   Optional macro WB_BYPASS_EN (see wb_regfile): same-cycle write-to-read
//   forwarding on both decode read ports.
//
// Ports
//   clock, reset_n            : clock and asynchronous active-low reset
//   ex_wb, ex_wb_valid        : incoming bundle and its valid qualifier
//   rs_addr/rs_data,
//   rt_addr/rt_data           : decode read ports
//   redirect_req, redirect_pc : held redirect request towards fetch
//   redirect_ack              : fetch has taken redirect_pc
//   wb_stall                  : upstream must hold while a redirect is open
//   retire_count              : committed (non-squashed) entries, wrapping
// ----------------------------------------------------------------------------
module wb_stage
  import fde_pkg::*;
#(
  parameter int FLUSH_DEPTH = 2,
  parameter int RF_DEPTH    = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [EXWB_W-1:0] ex_wb,
  input  logic              ex_wb_valid,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic [31:0]       rs_data,
  output logic [31:0]       rt_data,
  output logic              redirect_req,
  output logic [31:0]       redirect_pc,
  input  logic              redirect_ack,
  output logic              wb_stall,
  output logic [31:0]       retire_count
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_DEPTH);

  // Bundle fields
  logic [31:0] in_wdata;
  logic [31:0] in_pc;
  logic [4:0]  in_dest;
  logic        in_br;
  logic        in_we;

  assign in_wdata = ex_wb[WDATA_LSB +: 32];
  assign in_pc    = ex_wb[PC_LSB +: 32];
  assign in_dest  = ex_wb[DEST_LSB +: 5];
  assign in_br    = ex_wb[BR_BIT];
  assign in_we    = ex_wb[WE_BIT];

  wb_state_t   state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic [31:0] retire_q, retire_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        redirect_req_q, redirect_req_d;
  logic        wb_stall_q, wb_stall_d;

  logic accept;
  logic commit;
  logic rf_we;

  // Entries are ignored while a redirect is open; accepted entries in FLUSH
  // are squashed, so only IDLE acceptance commits.
  assign accept = ex_wb_valid && (state_q != REDIRECT);
  assign commit = accept && (state_q == IDLE);
  assign rf_we  = commit && in_we && (in_dest != 5'd0);

  // State register and datapath flops
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      flush_cnt_q    <= '0;
      retire_q       <= '0;
      redirect_pc_q  <= '0;
      redirect_req_q <= 1'b0;
      wb_stall_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      retire_q       <= retire_d;
      redirect_pc_q  <= redirect_pc_d;
      redirect_req_q <= redirect_req_d;
      wb_stall_q     <= wb_stall_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (commit && in_br) begin
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        if (redirect_req_q && redirect_ack) begin
          state_d = (FLUSH_DEPTH == 0) ? IDLE : FLUSH;
        end
      end
      FLUSH: begin
        // Only valid entries consume the squash budget.
        if (ex_wb_valid && (flush_cnt_q == 4'd1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    flush_cnt_d    = flush_cnt_q;
    retire_d       = retire_q;
    redirect_pc_d  = redirect_pc_q;
    redirect_req_d = redirect_req_q;
    wb_stall_d     = wb_stall_q;
    case (state_q)
      IDLE: begin
        if (commit) begin
          retire_d = retire_q + 32'd1;
          if (in_br) begin
            redirect_pc_d  = in_pc;
            redirect_req_d = 1'b1;
            wb_stall_d     = 1'b1;
          end
        end
      end
      REDIRECT: begin
        if (redirect_req_q && redirect_ack) begin
          redirect_req_d = 1'b0;
          wb_stall_d     = 1'b0;
          flush_cnt_d    = FLUSH_INIT;
        end
      end
      FLUSH: begin
        if (ex_wb_valid && (flush_cnt_q != 4'd0)) begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: begin
        flush_cnt_d = '0;
      end
    endcase
  end

  assign redirect_req = redirect_req_q;
  assign redirect_pc  = redirect_pc_q;
  assign wb_stall     = wb_stall_q;
  assign retire_count = retire_q;

  wb_regfile #(
    .RF_DEPTH (RF_DEPTH)
  ) u_regfile (
    .clock   (clock),
    .reset_n (reset_n),
    .we      (rf_we),
    .waddr   (in_dest),
    .wdata   (in_wdata),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

endmodule

// File: tb/tb_wb_stage.sv
// ----------------------------------------------------------------------------
// tb_wb_stage
//   Directed scenarios followed by random traffic for wb_stage, checked
//   against a behavioural model: a register array, a "redirect pending" flag,
//   a count of entries still to squash and a retire counter.
// ----------------------------------------------------------------------------
module tb_wb_stage;

  localparam int FLUSH_DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [70:0] ex_wb;
  logic        ex_wb_valid;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        redirect_req;
  logic [31:0] redirect_pc;
  logic        redirect_ack;
  logic        wb_stall;
  logic [31:0] retire_count;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model
  logic [31:0] m_rf [32];
  bit          m_pending;
  logic [31:0] m_pc;
  int          m_squash;
  logic [31:0] m_retire;

  wb_stage #(
    .FLUSH_DEPTH (FLUSH_DEPTH),
    .RF_DEPTH    (32)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ex_wb        (ex_wb),
    .ex_wb_valid  (ex_wb_valid),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .redirect_req (redirect_req),
    .redirect_pc  (redirect_pc),
    .redirect_ack (redirect_ack),
    .wb_stall     (wb_stall),
    .retire_count (retire_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_pending = 1'b0;
    m_pc      = '0;
    m_squash  = 0;
    m_retire  = '0;
  endtask

  // Expected read-port value for the inputs currently on the bus.
  function automatic logic [31:0] exp_read(input logic [4:0] a);
`ifdef WB_BYPASS_EN
    if (a != 5'd0 && ex_wb_valid && !m_pending && m_squash == 0 &&
        ex_wb[70] && ex_wb[68:64] == a)
      return ex_wb[31:0];
`endif
    if (a == 5'd0) return 32'd0;
    return m_rf[a];
  endfunction

  // Model reaction to one rising clock edge.
  task automatic model_edge(input bit v, input bit we, input bit br,
                            input logic [4:0] dest, input logic [31:0] pc,
                            input logic [31:0] wd, input bit ack);
    if (m_pending) begin
      if (ack) begin
        m_pending = 1'b0;
        m_squash  = FLUSH_DEPTH;
      end
    end else if (v) begin
      if (m_squash > 0) begin
        m_squash--;
      end else begin
        if (we && dest != 5'd0) m_rf[dest] = wd;
        m_retire = m_retire + 32'd1;
        if (br) begin
          m_pending = 1'b1;
          m_pc      = pc;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("rs_data", rs_data, exp_read(rs_addr));
    chk("rt_data", rt_data, exp_read(rt_addr));
    chk("redirect_req", {31'd0, redirect_req}, {31'd0, m_pending});
    chk("redirect_pc", redirect_pc, m_pc);
    chk("wb_stall", {31'd0, wb_stall}, {31'd0, m_pending});
    chk("retire_count", retire_count, m_retire);
  endtask

  // One transaction: called just after a falling edge, drives inputs,
  // checks, crosses the rising edge and returns at the next falling edge.
  task automatic step(input bit v, input bit we, input bit br,
                      input logic [4:0] dest, input logic [31:0] pc,
                      input logic [31:0] wd, input logic [4:0] rs,
                      input logic [4:0] rt, input bit ack);
    ex_wb        = {we, br, dest, pc, wd};
    ex_wb_valid  = v;
    rs_addr      = rs;
    rt_addr      = rt;
    redirect_ack = ack;
    #1;
    check_all();
    $display("txn t=%0t v=%b we=%b br=%b dest=%0d wd=%h ack=%b rs=%0d rt=%0d retire=%0d",
             $time, v, we, br, dest, wd, ack, rs, rt, retire_count);
    @(posedge clock);
    model_edge(v, we, br, dest, pc, wd, ack);
    @(negedge clock);
    ex_wb_valid  = 1'b0;
    redirect_ack = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    ex_wb        = '0;
    ex_wb_valid  = 1'b0;
    rs_addr      = 5'd5;
    rt_addr      = 5'd0;
    redirect_ack = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    chk("reset_redirect_req", {31'd0, redirect_req}, 32'd0);
    chk("reset_retire", retire_count, 32'd0);
    chk("reset_rs_data", rs_data, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // 1. Basic write
    step(1, 1, 0, 5'd5, 32'h0, 32'hDEADBEEF, 5'd5, 5'd0, 0);
    #1;
    chk("basic_r5", rs_data, 32'hDEADBEEF);
    chk("basic_retire", retire_count, 32'd1);

    // 2. r0 protection
    step(1, 1, 0, 5'd0, 32'h0, 32'h00001234, 5'd0, 5'd5, 0);
    #1;
    chk("r0_read", rs_data, 32'd0);
    chk("r0_retire", retire_count, 32'd2);

    // 3. Redirect held across a delayed ack; stalled entries are dropped
    step(1, 0, 1, 5'd0, 32'h00000040, 32'h0, 5'd5, 5'd9, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_req", {31'd0, redirect_req}, 32'd1);
      chk("hold_pc", redirect_pc, 32'h00000040);
      chk("hold_stall", {31'd0, wb_stall}, 32'd1);
      step(1, 1, 0, 5'd9, 32'h0, $urandom, 5'd5, 5'd9, 0);
    end
    step(0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd9, 1);
    #1;
    chk("stall_no_write_r9", rt_data, 32'd0);
    chk("ack_req_low", {31'd0, redirect_req}, 32'd0);

    // 4. Squash two valid entries separated by an idle cycle
    step(1, 1, 0, 5'd7, 32'h0, 32'd1, 5'd7, 5'd0, 0);
    step(0, 1, 0, 5'd7, 32'h0, 32'd9, 5'd7, 5'd0, 0);
    step(1, 1, 0, 5'd7, 32'h0, 32'd2, 5'd7, 5'd0, 0);
    #1;
    chk("flush_r7", rs_data, 32'd0);
    chk("flush_retire", retire_count, 32'd3);
    step(1, 1, 0, 5'd7, 32'h0, 32'd3, 5'd7, 5'd0, 0);
    #1;
    chk("post_flush_r7", rs_data, 32'd3);
    chk("post_flush_retire", retire_count, 32'd4);

    // 5. Same-cycle write and read
    ex_wb       = {1'b1, 1'b0, 5'd3, 32'h0, 32'hA5A5A5A5};
    ex_wb_valid = 1'b1;
    rt_addr     = 5'd3;
    #1;
`ifdef WB_BYPASS_EN
    chk("same_cycle_rt", rt_data, 32'hA5A5A5A5);
`else
    chk("same_cycle_rt", rt_data, 32'd0);
`endif
    step(1, 1, 0, 5'd3, 32'h0, 32'hA5A5A5A5, 5'd5, 5'd3, 0);
    #1;
    chk("next_cycle_rt", rt_data, 32'hA5A5A5A5);

    // 6. Asynchronous reset while a redirect is open
    step(1, 0, 1, 5'd0, 32'h00000080, 32'h0, 5'd5, 5'd3, 0);
    #1;
    chk("pre_reset_req", {31'd0, redirect_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_req", {31'd0, redirect_req}, 32'd0);
    chk("async_reset_stall", {31'd0, wb_stall}, 32'd0);
    chk("async_reset_pc", redirect_pc, 32'd0);
    chk("async_reset_r5", rs_data, 32'd0);
    chk("async_reset_retire", retire_count, 32'd0);
    model_reset();
    reset_n     = 1'b1;
    ex_wb       = {1'b1, 1'b0, 5'd5, 32'h0, 32'h00001111};
    ex_wb_valid = 1'b1;
    rs_addr     = 5'd4;
    @(posedge clock);
    model_edge(1, 1, 0, 5'd5, 32'h0, 32'h00001111, 0);
    @(negedge clock);
    ex_wb_valid = 1'b0;
    rs_addr     = 5'd5;
    #1;
    chk("post_reset_r5", rs_data, 32'h00001111);
    chk("post_reset_retire", retire_count, 32'd1);

    // Random traffic against the model
    for (int n = 0; n < 500; n++) begin
      logic [4:0] d, a, b;
      d = 5'($urandom_range(0, 31));
      a = ($urandom_range(0, 1) == 0) ? d : 5'($urandom_range(0, 31));
      b = ($urandom_range(0, 1) == 0) ? d : 5'($urandom_range(0, 31));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 7) == 0, d, $urandom, $urandom, a, b,
           $urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Writeback stage, directly downstream of the execute stage. Consumes the 71-bit EX_WB bundle:
- commits results into the 32x32 general register file;
- exposes two read ports to decode;
- turns branch-flagged entries into a held redirect request to fetch;
- squashes a fixed number of wrong-path entries that follow a taken branch.

Parameters:
FLUSH_DEPTH, 2, number of valid EX_WB entries squashed after a redirect is acknowledged (0..15)
RF_DEPTH, 32, register count (address width fixed at 5)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
ex_wb  in  71  [31:0] wdata, [63:32] pc, [68:64] dest, [69] branch flag, [70] writeback enable
ex_wb_valid  in  1  ex_wb holds a real entry this cycle
rs_addr  in  5  decode read address A
rt_addr  in  5  decode read address B
rs_data  out  32  register value at rs_addr
rt_data  out  32  register value at rt_addr
redirect_req  out  1  fetch must load redirect_pc
redirect_pc  out  32  branch target
redirect_ack  in  1  fetch has taken redirect_pc
wb_stall  out  1  upstream must hold; input is ignored
retire_count  out  32  count of committed (non-squashed) entries

Behaviour:
- Reset (reset_n low, asynchronous): all registers = 0, redirect_req = 0, redirect_pc = 0, wb_stall = 0, retire_count = 0, state = IDLE. The reset takes effect immediately, including mid-REDIRECT or mid-FLUSH; any pending redirect is dropped.
- Acceptance: an entry is accepted when ex_wb_valid = 1 and state != REDIRECT.
- States: IDLE, REDIRECT, FLUSH.
- IDLE, on an accepted entry:
  - If enable[70] = 1 and dest != 0: rf[dest] <= wdata at this edge. The value is readable on the following cycle (1-cycle latency).
  - retire_count += 1. The counter wraps from 0xFFFFFFFF to 0.
  - If branch[69] = 1: redirect_pc <= pc, redirect_req <= 1, wb_stall <= 1, next state = REDIRECT. An entry with both branch and enable set also performs its register write (link).
- REDIRECT:
  - redirect_req, redirect_pc and wb_stall are held stable; ex_wb is ignored.
  - redirect_ack is sampled only while redirect_req = 1. On ack: redirect_req <= 0, wb_stall <= 0, flush counter <= FLUSH_DEPTH.
  - Next state after ack is FLUSH, or IDLE if FLUSH_DEPTH = 0.
- FLUSH:
  - Each valid entry is squashed: no register write, no redirect, no retire_count increment. The flush counter decrements by 1.
  - When a squash brings the counter to 0, next state = IDLE.
  - Cycles with ex_wb_valid = 0 do not decrement the counter.
- Register 0:
  - Writes to r0 are discarded; reads of r0 always return 0.
  - A read of any other address returns the stored value combinationally.
- Simultaneous write and read of the same address in the same cycle: governed by the optional feature below.

Optional Feature:
WB_BYPASS_EN
- Defined: if a write is committing this cycle (accepted, enable = 1, dest != 0) and rs_addr or rt_addr equals dest, that port returns wdata combinationally.
- Undefined: that port returns the pre-write value, and decode must space dependent instructions by one extra cycle.

Decomposition:
- Package fde_pkg holds:
  - EX_WB field localparams: EXWB_W = 71, WDATA_LSB = 0, PC_LSB = 32, DEST_LSB = 64, BR_BIT = 69, WE_BIT = 70;
  - the wb_state_t enum {IDLE, REDIRECT, FLUSH}.
- Sub-module wb_regfile contains the 32x32 array, one write port, two async read ports, r0 forced to zero, and the WB_BYPASS_EN mux.
- The state machine, flush counter and retire counter stay in wb_stage.

Test Plan:
1. Basic write: valid entry with enable = 1, dest = 5, wdata = 0xDEADBEEF → next cycle rs_addr = 5 reads 0xDEADBEEF and retire_count = 1.
2. r0 protection: enable = 1, dest = 0, wdata = 0x00001234 → rs_addr = 0 reads 0; retire_count still increments.
3. Redirect with delayed ack: branch = 1, pc = 0x00000040, ack held low 3 cycles →
   - redirect_req = 1, redirect_pc = 0x40 and wb_stall = 1 stay stable throughout;
   - entries presented during stall are not written.
4. Flush after ack (FLUSH_DEPTH = 2): after the ack, two valid entries with enable = 1, dest = 7, wdata = 1 and 2, separated by one invalid cycle → neither is written and retire_count is unchanged. A third entry with wdata = 3 → r7 = 3.
5. Same-cycle bypass: write dest = 3, wdata = 0xA5A5A5A5 with rt_addr = 3 in the same cycle →
   - WB_BYPASS_EN defined: rt_data = 0xA5A5A5A5;
   - WB_BYPASS_EN undefined: rt_data = 0 that cycle and 0xA5A5A5A5 the next.
6. Reset mid-REDIRECT: pull reset_n low between clock edges → redirect_req = 0 immediately, r5 reads 0, retire_count = 0. After release, a new write is accepted on the first edge.
